// File: rtl/i2c_master_writer.sv
// i2c_master_writer
//   Write-only I2C master. A start pulse in IDLE captures {addr,access} and
//   NUM_BYTE data bytes, then the block issues START, the address byte,
//   every data byte (MSB first, most-significant byte first) and STOP. The
//   slave ACK is sampled after every byte. A NACK ends the transfer early
//   with a STOP and raises nack.
//
// Ports
//   clk      system clock
//   reset_n  asynchronous active-low reset; releases the bus at once
//   start    one-cycle request, only looked at in IDLE
//   addr     7-bit slave address (BYTE_SIZE-1 bits)
//   access   R/W bit, sent as the LSB of the address byte
//   data     payload, data[DATA_WIDTH-1 -: BYTE_SIZE] goes out first
//   busy     high while a transaction is in flight
//   done     one-cycle pulse when a transaction ends (ack or nack)
//   nack     set when a NACK ended the transfer; cleared by the next start
//   i2c_SCL  push-pull SCL
//   i2c_SDA  open-drain SDA (0 = drive low, z = release)
//
// Timing
//   One bit cell is four quarters of QUARTER clocks: q0/q1 SCL low, q2/q3
//   SCL high. SCL and SDA come straight from flops, and SDA is held for the
//   first clock of q0 so it always moves one clock after SCL has fallen.
//   QUARTER must be at least 2.

module i2c_master_writer #(
  parameter int CLK_FREQ     = 50,
  parameter int I2C_CLK_FREQ = 100,
  parameter int NUM_BYTE     = 4,
  parameter int BYTE_SIZE    = 8,
  parameter int DATA_WIDTH   = NUM_BYTE * BYTE_SIZE,
  parameter int QUARTER      = CLK_FREQ * 1000 / (I2C_CLK_FREQ * 4)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BYTE_SIZE-2:0]  addr,
  input  logic                  access,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic                  nack,
  output logic                  i2c_SCL,
  inout  wire                   i2c_SDA
);

  localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int BW = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;
  localparam int NW = (NUM_BYTE > 1) ? $clog2(NUM_BYTE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ACK, S_DATA, S_DACK, S_STOP
  } state_t;

  state_t                state, state_nx;
  logic [QW-1:0]         qcnt;      // clocks inside the current quarter
  logic [1:0]            phase;     // q0..q3 inside the current bit cell
  logic [BW-1:0]         bcnt;      // bit inside the current byte
  logic [NW-1:0]         ncnt;      // data byte index
  logic [BYTE_SIZE-1:0]  addr_sr;
  logic [DATA_WIDTH-1:0] data_sr;
  logic                  ack_n;     // SDA level sampled in the ack cell
  logic                  scl_q, sda_low_q;
  logic                  scl_d, sda_low_d;

  logic tick, cell_end, last_bit, last_byte, hold, cur_bit, smp;

  assign tick      = (state != S_IDLE) && (qcnt == QW'(QUARTER - 1));
  assign cell_end  = tick && (phase == 2'd3);
  assign last_bit  = (bcnt == BW'(BYTE_SIZE - 1));
  assign last_byte = (ncnt == NW'(NUM_BYTE - 1));
  // first clock of q0: SCL is just being pulled low, keep SDA where it is
  assign hold      = (phase == 2'd0) && (qcnt == '0);
  assign cur_bit   = (state == S_ADDR) ? addr_sr[BYTE_SIZE-1]
                                       : data_sr[DATA_WIDTH-1];
  assign smp       = ((state == S_ACK) || (state == S_DACK)) &&
                     (phase == 2'd2) && (qcnt == '0);

  assign busy    = (state != S_IDLE);
  assign i2c_SCL = scl_q;
  assign i2c_SDA = sda_low_q ? 1'b0 : 1'bz;

  // ---------------------------------------------------------------------
  // next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_START;
      S_START: if (tick) state_nx = S_ADDR;
      S_ADDR:  if (cell_end && last_bit) state_nx = S_ACK;
      S_ACK:   if (cell_end) state_nx = ack_n ? S_STOP : S_DATA;
      S_DATA:  if (cell_end && last_bit) state_nx = S_DACK;
      S_DACK:  if (cell_end) state_nx = (ack_n || last_byte) ? S_STOP : S_DATA;
      S_STOP:  if (cell_end) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // bus levels for the current quarter; registered below
  // ---------------------------------------------------------------------
  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    unique case (state)
      S_IDLE:  ;
      S_START: sda_low_d = 1'b1;
      S_ADDR, S_DATA: begin
        scl_d     = phase[1];
        sda_low_d = hold ? sda_low_q : ~cur_bit;
      end
      S_ACK, S_DACK: begin
        scl_d     = phase[1];
        sda_low_d = hold ? sda_low_q : 1'b0;
      end
      S_STOP: begin
        unique case (phase)
          2'd0:    begin scl_d = 1'b0; sda_low_d = hold ? sda_low_q : 1'b1; end
          2'd1:    sda_low_d = 1'b1;
          default: sda_low_d = 1'b0;   // q2 rising SDA is the STOP, q3 bus free
        endcase
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // state register and datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      phase     <= '0;
      bcnt      <= '0;
      ncnt      <= '0;
      addr_sr   <= '0;
      data_sr   <= '0;
      ack_n     <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
    end else begin
      state     <= state_nx;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
      done      <= cell_end && (state == S_STOP);

      if (state == S_IDLE) begin
        qcnt  <= '0;
        phase <= '0;
        bcnt  <= '0;
        ncnt  <= '0;
        if (start) begin
          addr_sr <= {addr, access};
          data_sr <= data;
          nack    <= 1'b0;
        end
      end else begin
        qcnt <= tick ? '0 : qcnt + QW'(1);
        // START is a single quarter; bit cells begin at q0 right after it
        if (tick) phase <= (state == S_START) ? 2'd0 : phase + 2'd1;

        if (smp) ack_n <= i2c_SDA;

        if (cell_end) begin
          unique case (state)
            S_ADDR: begin
              addr_sr <= {addr_sr[BYTE_SIZE-2:0], 1'b0};
              bcnt    <= last_bit ? '0 : bcnt + BW'(1);
            end
            S_DATA: begin
              data_sr <= {data_sr[DATA_WIDTH-2:0], 1'b0};
              bcnt    <= last_bit ? '0 : bcnt + BW'(1);
            end
            S_ACK:  if (ack_n) nack <= 1'b1;
            S_DACK: begin
              if (ack_n)           nack <= 1'b1;
              else if (!last_byte) ncnt <= ncnt + NW'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
